// File: rtl/tb_prefetch_server.sv
// rtl/tb_prefetch_server.sv - host-side prefetch responder streaming S/T bases to the traceback engine
module tb_prefetch_server #(
  parameter int BP_WIDTH  = 2,
  parameter int POS_WIDTH = 10,
  parameter int PF_LEN    = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [1:0]           prefetch_request,
  input  logic [POS_WIDTH-1:0] in_block_x_startpoint,
  input  logic [POS_WIDTH-1:0] in_block_y_startpoint,
  input  logic [POS_WIDTH-1:0] prefetch_x_startpoint,
  input  logic [POS_WIDTH-1:0] prefetch_y_startpoint,
  input  logic                 done,
  output logic                 mem_rd_en,
  output logic [POS_WIDTH-1:0] mem_addr_s,
  output logic [POS_WIDTH-1:0] mem_addr_t,
  input  logic [BP_WIDTH-1:0]  mem_data_s,
  input  logic [BP_WIDTH-1:0]  mem_data_t,
  output logic [BP_WIDTH-1:0]  pf_s,
  output logic [BP_WIDTH-1:0]  pf_t,
  output logic                 pf_valid,
  output logic                 pf_target,
  output logic [CNT_WIDTH-1:0] pf_count,
  output logic                 pf_pad,
  output logic                 busy,
  output logic                 req_overrun
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_K = CNT_WIDTH'(PF_LEN - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   k_q, k_d;
  logic [POS_WIDTH-1:0]   xs_q, xs_d, ys_q, ys_d;
  logic                   tgt_q, tgt_d;
  logic                   pend_q, pend_d;
  logic                   ptgt_q, ptgt_d;
  logic [POS_WIDTH-1:0]   pxs_q, pxs_d, pys_q, pys_d;
  logic                   valid_q, valid_d;
  logic                   pad_q, pad_d;
  logic                   vtgt_q, vtgt_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovr_q, ovr_d;

  logic [POS_WIDTH-1:0]   k_ext;
  logic                   pad_now;
  logic                   any_req;
  logic                   accept_req;
  logic [1:0]             other_req;
  logic [POS_WIDTH-1:0]   acc_x, acc_y;

  // Underflow is decided by comparing the start point with k, so addresses never wrap
  assign k_ext      = POS_WIDTH'(k_q);
  assign pad_now    = (xs_q < k_ext) || (ys_q < k_ext);
  assign any_req    = |prefetch_request;
  // While busy, only a single request for the target not being served can be parked
  assign other_req  = tgt_q ? 2'b01 : 2'b10;
  assign accept_req = (prefetch_request == other_req) && !pend_q;
  assign acc_x      = tgt_q ? in_block_x_startpoint : prefetch_x_startpoint;
  assign acc_y      = tgt_q ? in_block_y_startpoint : prefetch_y_startpoint;

  // Next-state and next-pipeline logic; done overrides every other decision
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    ptgt_d  = ptgt_q;
    pxs_d   = pxs_q;
    pys_d   = pys_q;
    valid_d = 1'b0;
    pad_d   = 1'b0;
    vtgt_d  = 1'b0;
    cnt_d   = '0;
    ovr_d   = 1'b0;
    if (done) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_d = READ;
            k_d     = '0;
            tgt_d   = (prefetch_request == 2'b10);
            xs_d    = tgt_d ? prefetch_x_startpoint : in_block_x_startpoint;
            ys_d    = tgt_d ? prefetch_y_startpoint : in_block_y_startpoint;
            if (prefetch_request == 2'b11) begin
              pend_d = 1'b1;
              ptgt_d = 1'b1;
              pxs_d  = prefetch_x_startpoint;
              pys_d  = prefetch_y_startpoint;
            end
          end
        end
        READ: begin
          valid_d = 1'b1;
          pad_d   = pad_now;
          vtgt_d  = tgt_q;
          cnt_d   = LAST_K - k_q;
          k_d     = k_q + CNT_WIDTH'(1);
          if (k_q == LAST_K) begin
            state_d = DRAIN;
          end
          if (accept_req) begin
            pend_d = 1'b1;
            ptgt_d = ~tgt_q;
            pxs_d  = acc_x;
            pys_d  = acc_y;
          end else if (any_req) begin
            ovr_d = 1'b1;
          end
        end
        DRAIN: begin
          if (pend_q) begin
            state_d = READ;
            k_d     = '0;
            tgt_d   = ptgt_q;
            xs_d    = pxs_q;
            ys_d    = pys_q;
            pend_d  = 1'b0;
            ovr_d   = any_req;
          end else if (accept_req) begin
            // A request arriving on the drain beat starts straight away
            state_d = READ;
            k_d     = '0;
            tgt_d   = ~tgt_q;
            xs_d    = acc_x;
            ys_d    = acc_y;
          end else begin
            state_d = IDLE;
            ovr_d   = any_req;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      tgt_q   <= 1'b0;
      pend_q  <= 1'b0;
      ptgt_q  <= 1'b0;
      pxs_q   <= '0;
      pys_q   <= '0;
      valid_q <= 1'b0;
      pad_q   <= 1'b0;
      vtgt_q  <= 1'b0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      ptgt_q  <= ptgt_d;
      pxs_q   <= pxs_d;
      pys_q   <= pys_d;
      valid_q <= valid_d;
      pad_q   <= pad_d;
      vtgt_q  <= vtgt_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mem_rd_en   = (state_q == READ);
  assign mem_addr_s  = (mem_rd_en && !pad_now) ? (ys_q - k_ext) : '0;
  assign mem_addr_t  = (mem_rd_en && !pad_now) ? (xs_q - k_ext) : '0;
  assign pf_valid    = valid_q;
  assign pf_s        = (valid_q && !pad_q) ? mem_data_s : '0;
  assign pf_t        = (valid_q && !pad_q) ? mem_data_t : '0;
  assign pf_target   = vtgt_q;
  assign pf_count    = cnt_q;
  assign pf_pad      = pad_q;
  assign busy        = (state_q != IDLE) || pend_q;
  assign req_overrun = ovr_q;

endmodule

// File: tb/tb_tb_prefetch_server.sv
// tb/tb_tb_prefetch_server.sv - self-checking bench for tb_prefetch_server
module tb_tb_prefetch_server;

  localparam int BP_WIDTH  = 2;
  localparam int POS_WIDTH = 10;
  localparam int PF_LEN    = 32;
  localparam int CNT_WIDTH = 5;

  logic                 clk;
  logic                 reset_i;
  logic [1:0]           prefetch_request;
  logic [POS_WIDTH-1:0] in_block_x_startpoint, in_block_y_startpoint;
  logic [POS_WIDTH-1:0] prefetch_x_startpoint, prefetch_y_startpoint;
  logic                 done;
  logic                 mem_rd_en;
  logic [POS_WIDTH-1:0] mem_addr_s, mem_addr_t;
  logic [BP_WIDTH-1:0]  mem_data_s, mem_data_t;
  logic [BP_WIDTH-1:0]  pf_s, pf_t;
  logic                 pf_valid, pf_target, pf_pad, busy, req_overrun;
  logic [CNT_WIDTH-1:0] pf_count;

  logic [BP_WIDTH-1:0]  mem_s [0:1023];
  logic [BP_WIDTH-1:0]  mem_t [0:1023];

  int checks = 0;
  int errors = 0;

  // behavioural model: offset within the current burst (-1 idle, PF_LEN = drain beat)
  int m_off, m_xs, m_ys, m_pxs, m_pys;
  bit m_tgt, m_pend, m_ptgt, m_ovr;

  // burst statistics gathered from DUT outputs
  int st_beats, st_pads, st_tgt1, st_gaps, st_ovr, st_low;
  bit st_seen;

  typedef struct {
    logic [1:0] req;
    int x, y, px, py;
    int beats, pads, tgt1, gaps;
  } vec_t;
  vec_t tbl [7];

  tb_prefetch_server #(
    .BP_WIDTH(BP_WIDTH), .POS_WIDTH(POS_WIDTH), .PF_LEN(PF_LEN), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .reset_i(reset_i), .prefetch_request(prefetch_request),
    .in_block_x_startpoint(in_block_x_startpoint), .in_block_y_startpoint(in_block_y_startpoint),
    .prefetch_x_startpoint(prefetch_x_startpoint), .prefetch_y_startpoint(prefetch_y_startpoint),
    .done(done), .mem_rd_en(mem_rd_en), .mem_addr_s(mem_addr_s), .mem_addr_t(mem_addr_t),
    .mem_data_s(mem_data_s), .mem_data_t(mem_data_t), .pf_s(pf_s), .pf_t(pf_t),
    .pf_valid(pf_valid), .pf_target(pf_target), .pf_count(pf_count), .pf_pad(pf_pad),
    .busy(busy), .req_overrun(req_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sequence memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_data_s <= mem_s[mem_addr_s];
      mem_data_t <= mem_t[mem_addr_t];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_off = -1; m_pend = 0; m_tgt = 0; m_ovr = 0;
    m_xs = 0; m_ys = 0; m_pxs = 0; m_pys = 0; m_ptgt = 0;
  endfunction

  function automatic void stats_reset();
    st_beats = 0; st_pads = 0; st_tgt1 = 0; st_gaps = 0; st_ovr = 0; st_low = 0; st_seen = 0;
  endfunction

  // request/done rules applied at one clock edge
  function automatic void model_edge(input logic [1:0] req, input bit dn,
                                     input int ix, input int iy, input int px, input int py);
    logic [1:0] other;
    bit acc;
    m_ovr = 0;
    if (dn) begin
      m_off = -1;
      m_pend = 0;
      return;
    end
    if (m_off < 0) begin
      if (req != 2'b00) begin
        m_tgt = (req == 2'b10);
        m_xs  = m_tgt ? px : ix;
        m_ys  = m_tgt ? py : iy;
        m_off = 0;
        if (req == 2'b11) begin
          m_pend = 1; m_ptgt = 1; m_pxs = px; m_pys = py;
        end
      end
      return;
    end
    other = m_tgt ? 2'b01 : 2'b10;
    acc = (req == other) && !m_pend;
    if (req != 2'b00 && !acc) m_ovr = 1;
    if (acc) begin
      m_pend = 1;
      m_ptgt = !m_tgt;
      m_pxs  = m_ptgt ? px : ix;
      m_pys  = m_ptgt ? py : iy;
    end
    if (m_off < PF_LEN) begin
      m_off++;
    end else if (m_pend) begin
      m_tgt = m_ptgt; m_xs = m_pxs; m_ys = m_pys; m_pend = 0; m_off = 0;
    end else begin
      m_off = -1;
    end
  endfunction

  // compare every output against the model for the current cycle, and gather statistics
  task automatic check_cycle();
    bit rd, pad, v, bpad;
    int k, b;
    logic [POS_WIDTH-1:0] as, at;
    logic [BP_WIDTH-1:0] es, et;
    logic [CNT_WIDTH-1:0] cnt;
    rd  = (m_off >= 0) && (m_off < PF_LEN);
    k   = m_off;
    pad = rd && ((m_xs < k) || (m_ys < k));
    as  = (rd && !pad) ? POS_WIDTH'(m_ys - k) : '0;
    at  = (rd && !pad) ? POS_WIDTH'(m_xs - k) : '0;
    v   = (m_off >= 1) && (m_off <= PF_LEN);
    b   = m_off - 1;
    bpad = v && ((m_xs < b) || (m_ys < b));
    es  = (v && !bpad) ? mem_s[m_ys - b] : '0;
    et  = (v && !bpad) ? mem_t[m_xs - b] : '0;
    cnt = v ? CNT_WIDTH'(PF_LEN - m_off) : '0;
    chk("mem_port", {mem_rd_en, mem_addr_s, mem_addr_t}, {rd, as, at});
    chk("pf_beat", {pf_valid, pf_target, pf_count, pf_pad, pf_s, pf_t},
        {v, v && m_tgt, cnt, bpad, es, et});
    chk("status", {busy, req_overrun}, {(m_off >= 0) || m_pend, m_ovr});
    if (pf_valid) begin
      st_beats++;
      if (pf_pad) st_pads++;
      if (pf_target) st_tgt1++;
      if (st_seen) st_gaps += st_low;
      st_low = 0;
      st_seen = 1;
    end else if (st_seen) begin
      st_low++;
    end
    if (req_overrun) st_ovr++;
  endtask

  task automatic tick(input logic [1:0] req, input bit dn,
                      input int ix, input int iy, input int px, input int py);
    prefetch_request      = req;
    done                  = dn;
    in_block_x_startpoint = POS_WIDTH'(ix);
    in_block_y_startpoint = POS_WIDTH'(iy);
    prefetch_x_startpoint = POS_WIDTH'(px);
    prefetch_y_startpoint = POS_WIDTH'(py);
    @(posedge clk);
    model_edge(req, dn, ix, iy, px, py);
    #1;
    check_cycle();
    prefetch_request = 2'b00;
    done = 1'b0;
  endtask

  logic [34:0] all_outs;
  assign all_outs = {mem_rd_en, mem_addr_s, mem_addr_t, pf_s, pf_t, pf_valid,
                     pf_target, pf_count, pf_pad, busy, req_overrun};

  initial begin
    int ovr_cyc;
    for (int i = 0; i < 1024; i++) begin
      mem_s[i] = BP_WIDTH'($urandom);
      mem_t[i] = BP_WIDTH'($urandom);
    end
    mem_data_s = '0;
    mem_data_t = '0;
    prefetch_request = 2'b00;
    done = 1'b0;
    in_block_x_startpoint = '0; in_block_y_startpoint = '0;
    prefetch_x_startpoint = '0; prefetch_y_startpoint = '0;
    model_reset();
    stats_reset();

    //            req    x    y    px    py   beats pads tgt1 gaps
    tbl[0] = '{2'b01, 100, 200,    0,    0,  32,   0,   0,  0};
    tbl[1] = '{2'b10,   0,   0,    5,   40,  32,  26,  32,  0};
    tbl[2] = '{2'b11, 100, 200,    5,   40,  64,  26,  32,  1};
    tbl[3] = '{2'b01,   0,   0,    0,    0,  32,  31,   0,  0};
    tbl[4] = '{2'b01,  31, 1023,   0,    0,  32,   0,   0,  0};
    tbl[5] = '{2'b10,   0,   0,   30,  500,  32,   1,  32,  0};
    tbl[6] = '{2'b11,   2, 900, 1023,    3,  64,  57,  32,  1};

    // reset held for three cycles, then ten quiet cycles
    reset_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", all_outs, '0);
    end
    reset_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(2'b00, 0, 0, 0, 0, 0);
      chk("reset_quiet_rd", mem_rd_en, 0);
    end

    // single current-block burst, cycle-exact landmarks
    tick(2'b01, 0, 100, 200, 0, 0);
    for (int c = 1; c <= 35; c++) begin
      if (c == 1) chk("c1_read", {mem_rd_en, mem_addr_s, mem_addr_t, pf_valid, busy},
                      {1'b1, 10'd200, 10'd100, 1'b0, 1'b1});
      if (c == 2) chk("c2_beat", {pf_valid, pf_target, pf_count, pf_s, pf_t},
                      {1'b1, 1'b0, 5'd31, mem_s[200], mem_t[100]});
      if (c == 32) chk("c32_read", {mem_rd_en, mem_addr_s, mem_addr_t}, {1'b1, 10'd169, 10'd69});
      if (c == 33) chk("c33_drain", {mem_rd_en, pf_valid, pf_count, busy}, {1'b0, 1'b1, 5'd0, 1'b1});
      if (c == 34) chk("c34_idle", {pf_valid, busy}, 2'b00);
      tick(2'b00, 0, 0, 0, 0, 0);
    end

    // table-driven bursts
    for (int i = 0; i < 7; i++) begin
      stats_reset();
      tick(tbl[i].req, 0, tbl[i].x, tbl[i].y, tbl[i].px, tbl[i].py);
      repeat (74) tick(2'b00, 0, 0, 0, 0, 0);
      chk($sformatf("vec%0d_beats", i), st_beats, tbl[i].beats);
      chk($sformatf("vec%0d_pads", i), st_pads, tbl[i].pads);
      chk($sformatf("vec%0d_tgt1", i), st_tgt1, tbl[i].tgt1);
      chk($sformatf("vec%0d_gaps", i), st_gaps, tbl[i].gaps);
      chk($sformatf("vec%0d_ovr", i), st_ovr, 0);
    end

    // overrun: 10 parked at cycle 10, 01 dropped at cycle 12
    stats_reset();
    ovr_cyc = -1;
    tick(2'b01, 0, 100, 200, 0, 0);
    for (int c = 1; c <= 80; c++) begin
      tick((c == 10) ? 2'b10 : (c == 12) ? 2'b01 : 2'b00, 0, 300, 300, 700, 20);
      if (req_overrun) ovr_cyc = c + 1;
    end
    chk("ovr_count", st_ovr, 1);
    chk("ovr_cycle", ovr_cyc, 13);
    chk("ovr_tgt1_beats", st_tgt1, 32);
    chk("ovr_total_beats", st_beats, 64);

    // abort with done at cycle 15, fresh request at cycle 20
    tick(2'b01, 0, 300, 50, 0, 0);
    for (int c = 1; c <= 60; c++) begin
      if (c == 20) stats_reset();
      tick((c == 20) ? 2'b01 : 2'b00, (c == 15), 400, 10, 0, 0);
      if (c + 1 == 16) chk("abort_c16_rd", mem_rd_en, 0);
      if (c + 1 == 17) chk("abort_c17", {pf_valid, busy}, 2'b00);
      if (c + 1 == 21) chk("abort_restart", {mem_rd_en, mem_addr_s, mem_addr_t},
                           {1'b1, 10'd10, 10'd400});
    end
    chk("abort_restart_beats", st_beats, 32);
    chk("abort_restart_pads", st_pads, 21);

    // asynchronous reset in the middle of a burst
    tick(2'b11, 0, 500, 500, 600, 600);
    repeat (5) tick(2'b00, 0, 0, 0, 0, 0);
    #2 reset_i = 1'b0;
    #1 chk("async_reset", all_outs, '0);
    @(posedge clk);
    #1 reset_i = 1'b1;
    model_reset();
    repeat (3) tick(2'b00, 0, 0, 0, 0, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] rq;
      bit dn;
      int ix, iy, px, py;
      rq = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dn = ($urandom_range(0, 149) == 0);
      ix = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023);
      iy = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023);
      px = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023);
      py = $urandom_range(0, 1) ? $urandom_range(0, 40) : $urandom_range(0, 1023);
      tick(rq, dn, ix, iy, px, py);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
